// File: rtl/alu_op_sequencer_if.sv
// Decode-to-execute handshake bundle for alu_op_sequencer.
// master = decode/execute side, slave = sequencer.
interface alu_op_sequencer_if #(
  parameter int unsigned CTRL_W = 4
);
  logic              InValid;
  logic              InReady;
  logic [3:0]        ALUOp;
  logic [31:0]       Instruction;
  logic              OutValid;
  logic              OutReady;
  logic [CTRL_W-1:0] ALUControl;
  logic              Illegal;
  logic              Busy;

  modport master (
    output InValid, ALUOp, Instruction, OutReady,
    input  InReady, OutValid, ALUControl, Illegal, Busy
  );

  modport slave (
    input  InValid, ALUOp, Instruction, OutReady,
    output InReady, OutValid, ALUControl, Illegal, Busy
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Registered ALU control decoder with valid/ready handshake and multi-cycle occupancy tracking.
// Optional macro ALU_DIV_EN enables R-type DIV (funct 011010) with DIV_LAT occupancy.
module alu_op_sequencer #(
  parameter int unsigned CTRL_W  = 4,
  parameter int unsigned FUNCT_W = 6,
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned DIV_LAT = 8
) (
  input logic               Clk,
  input logic               Rst_n,
  alu_op_sequencer_if.slave bus
);

  localparam int unsigned MaxLat = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int unsigned CntW   = $clog2(MaxLat + 1);

  localparam logic [CntW-1:0]   MulLoad = CntW'(MUL_LAT - 1);
  localparam logic [CTRL_W-1:0] CtrlAnd = CTRL_W'(0);
  localparam logic [CTRL_W-1:0] CtrlOr  = CTRL_W'(1);
  localparam logic [CTRL_W-1:0] CtrlAdd = CTRL_W'(2);
  localparam logic [CTRL_W-1:0] CtrlMul = CTRL_W'(3);
  localparam logic [CTRL_W-1:0] CtrlSub = CTRL_W'(6);
  localparam logic [CTRL_W-1:0] CtrlSlt = CTRL_W'(7);
`ifdef ALU_DIV_EN
  localparam logic [CntW-1:0]   DivLoad = CntW'(DIV_LAT - 1);
  localparam logic [CTRL_W-1:0] CtrlDiv = CTRL_W'(8);
`endif

  typedef enum logic [1:0] {StIdle, StHold, StBusy} state_e;

  state_e            state_q, state_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              illegal_q, illegal_d;
  logic [CntW-1:0]   load_q, load_d;   // occupancy-1 of the held op; 0 means single-cycle
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic [CTRL_W-1:0]  dec_ctrl;
  logic               dec_illegal;
  logic [CntW-1:0]    dec_load;
  logic [FUNCT_W-1:0] funct;
  logic               multi;
  logic               unused_instr;

  assign funct        = bus.Instruction[FUNCT_W-1:0];
  assign unused_instr = ^bus.Instruction[31:FUNCT_W];
  assign multi        = (load_q != '0);

  always_comb begin
    dec_ctrl    = CtrlAdd;
    dec_illegal = 1'b0;
    dec_load    = '0;
    unique case (bus.ALUOp)
      4'b0000: dec_ctrl = CtrlAdd;
      4'b0001: dec_ctrl = CtrlSub;
      4'b0011: begin
        dec_ctrl = CtrlMul;
        dec_load = MulLoad;
      end
      4'b0100: dec_ctrl = CtrlAnd;
      4'b0101: dec_ctrl = CtrlOr;
      4'b0111: dec_ctrl = CtrlSlt;
      4'b0010: begin
        if      (funct == FUNCT_W'(6'b100000)) dec_ctrl = CtrlAdd;
        else if (funct == FUNCT_W'(6'b100010)) dec_ctrl = CtrlSub;
        else if (funct == FUNCT_W'(6'b100100)) dec_ctrl = CtrlAnd;
        else if (funct == FUNCT_W'(6'b100101)) dec_ctrl = CtrlOr;
        else if (funct == FUNCT_W'(6'b101010)) dec_ctrl = CtrlSlt;
        else if (funct == FUNCT_W'(6'b000010)) begin
          dec_ctrl = CtrlMul;
          dec_load = MulLoad;
        end
`ifdef ALU_DIV_EN
        else if (funct == FUNCT_W'(6'b011010)) begin
          dec_ctrl = CtrlDiv;
          dec_load = DivLoad;
        end
`endif
        else dec_illegal = 1'b1;
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    ctrl_d    = ctrl_q;
    illegal_d = illegal_q;
    load_d    = load_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.InValid) begin
          ctrl_d    = dec_ctrl;
          illegal_d = dec_illegal;
          load_d    = dec_load;
          state_d   = StHold;
        end
      end
      StHold: begin
        if (bus.OutReady) begin
          if (multi) begin
            state_d = StBusy;
            cnt_d   = load_q;
          end else if (bus.InValid) begin
            ctrl_d    = dec_ctrl;
            illegal_d = dec_illegal;
            load_d    = dec_load;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StBusy: begin
        // Leave on the last busy cycle; never counts below 1.
        if (cnt_q <= CntW'(1)) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= StIdle;
      ctrl_q    <= '0;
      illegal_q <= 1'b0;
      load_q    <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      illegal_q <= illegal_d;
      load_q    <= load_d;
      cnt_q     <= cnt_d;
    end
  end

  // InReady is gated by reset so it reads 0 while Rst_n is held low.
  assign bus.InReady    = Rst_n && ((state_q == StIdle) ||
                                    ((state_q == StHold) && !multi && bus.OutReady));
  assign bus.OutValid   = (state_q == StHold);
  assign bus.Busy       = (state_q == StBusy);
  assign bus.ALUControl = ctrl_q;
  assign bus.Illegal    = illegal_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed self-checking bench for alu_op_sequencer (default parameters).
// Honours ALU_DIV_EN to exercise the DIV path when the design is built with it.
module tb_alu_op_sequencer;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  alu_op_sequencer_if #(.CTRL_W(4)) bus ();

  alu_op_sequencer #(
    .CTRL_W (4),
    .FUNCT_W(6),
    .MUL_LAT(4),
    .DIV_LAT(8)
  ) dut (
    .Clk  (clk),
    .Rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [5:0] fn,
                       input logic rdy);
    bus.InValid     = v;
    bus.ALUOp       = op;
    bus.Instruction = {26'h2a5_5a5a, fn};
    bus.OutReady    = rdy;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 4'b0000, 6'd0, 1'b0);
    #12;
    n_checks++; if (bus.OutValid !== 1'b0) begin n_fail++;
      $display("FAIL reset_outvalid got %b want 0", bus.OutValid); end
    n_checks++; if (bus.ALUControl !== 4'd0) begin n_fail++;
      $display("FAIL reset_ctrl got %0d want 0", bus.ALUControl); end
    n_checks++; if (bus.Illegal !== 1'b0) begin n_fail++;
      $display("FAIL reset_illegal got %b want 0", bus.Illegal); end
    n_checks++; if (bus.Busy !== 1'b0) begin n_fail++;
      $display("FAIL reset_busy got %b want 0", bus.Busy); end
    n_checks++; if (bus.InReady !== 1'b0) begin n_fail++;
      $display("FAIL reset_inready got %b want 0", bus.InReady); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++; if (bus.InReady !== 1'b1) begin n_fail++;
      $display("FAIL post_reset_inready got %b want 1", bus.InReady); end
  endtask

  task automatic test_single();
    tick();
    drive(1'b1, 4'b0001, 6'd0, 1'b1);
    tick();
    n_checks++; if (bus.OutValid !== 1'b1) begin n_fail++;
      $display("FAIL sub_outvalid got %b want 1", bus.OutValid); end
    n_checks++; if (bus.ALUControl !== 4'd6) begin n_fail++;
      $display("FAIL sub_ctrl got %0d want 6", bus.ALUControl); end
    n_checks++; if (bus.Illegal !== 1'b0 || bus.Busy !== 1'b0) begin n_fail++;
      $display("FAIL sub_flags got ill=%b busy=%b want 0 0", bus.Illegal, bus.Busy); end
    bus.InValid = 1'b0;
    tick();
    n_checks++; if (bus.OutValid !== 1'b0 || bus.InReady !== 1'b1) begin n_fail++;
      $display("FAIL sub_release got ov=%b ir=%b want 0 1", bus.OutValid, bus.InReady); end
  endtask

  task automatic test_back_to_back();
    logic [5:0] fn [3];
    logic [3:0] ec [3];
    fn[0] = 6'b100000; ec[0] = 4'd2;
    fn[1] = 6'b100010; ec[1] = 4'd6;
    fn[2] = 6'b100100; ec[2] = 4'd0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'b0010, fn[i], 1'b1);
      #1;
      n_checks++; if (bus.InReady !== 1'b1) begin n_fail++;
        $display("FAIL b2b_inready[%0d] got %b want 1", i, bus.InReady); end
      tick();
      n_checks++; if (bus.ALUControl !== ec[i] || bus.OutValid !== 1'b1) begin n_fail++;
        $display("FAIL b2b_ctrl[%0d] got %0d ov=%b want %0d ov=1", i, bus.ALUControl,
                 bus.OutValid, ec[i]); end
    end
    bus.InValid = 1'b0;
    tick();
    n_checks++; if (bus.OutValid !== 1'b0) begin n_fail++;
      $display("FAIL b2b_drain got ov=%b want 0", bus.OutValid); end
  endtask

  task automatic test_multi(input logic [5:0] fn, input logic [3:0] op,
                            input logic [3:0] ec, input int busy_cycles);
    drive(1'b1, op, fn, 1'b1);
    tick();
    bus.InValid = 1'b0;
    #1;
    n_checks++; if (bus.ALUControl !== ec || bus.OutValid !== 1'b1) begin n_fail++;
      $display("FAIL multi_hold got ctrl=%0d ov=%b want %0d 1", bus.ALUControl,
               bus.OutValid, ec); end
    n_checks++; if (bus.InReady !== 1'b0 || bus.Busy !== 1'b0) begin n_fail++;
      $display("FAIL multi_hold_ready got ir=%b busy=%b want 0 0", bus.InReady, bus.Busy); end
    for (int i = 0; i < busy_cycles; i++) begin
      tick();
      n_checks++;
      if (bus.Busy !== 1'b1 || bus.InReady !== 1'b0 || bus.OutValid !== 1'b0) begin n_fail++;
        $display("FAIL multi_busy[%0d] got busy=%b ir=%b ov=%b want 1 0 0", i, bus.Busy,
                 bus.InReady, bus.OutValid); end
    end
    tick();
    n_checks++; if (bus.Busy !== 1'b0 || bus.InReady !== 1'b1) begin n_fail++;
      $display("FAIL multi_done got busy=%b ir=%b want 0 1", bus.Busy, bus.InReady); end
  endtask

  task automatic test_hold();
    drive(1'b1, 4'b0111, 6'd0, 1'b0);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(i[0], 4'(i), 6'(i * 7), 1'b0);
      #1;
      n_checks++;
      if (bus.ALUControl !== 4'd7 || bus.OutValid !== 1'b1 || bus.InReady !== 1'b0) begin
        n_fail++;
        $display("FAIL hold[%0d] got ctrl=%0d ov=%b ir=%b want 7 1 0", i, bus.ALUControl,
                 bus.OutValid, bus.InReady); end
      tick();
    end
    drive(1'b0, 4'b0000, 6'd0, 1'b1);
    #1;
    n_checks++; if (bus.InReady !== 1'b1 || bus.ALUControl !== 4'd7) begin n_fail++;
      $display("FAIL hold_release got ir=%b ctrl=%0d want 1 7", bus.InReady,
               bus.ALUControl); end
    tick();
    n_checks++; if (bus.OutValid !== 1'b0) begin n_fail++;
      $display("FAIL hold_consumed got ov=%b want 0", bus.OutValid); end
  endtask

  task automatic test_decode();
    logic [3:0] op [8];
    logic [5:0] fn [8];
    logic [3:0] ec [8];
    logic       ei [8];
    op[0] = 4'b1111; fn[0] = 6'b000000; ec[0] = 4'd2; ei[0] = 1'b1;
    op[1] = 4'b0010; fn[1] = 6'b111111; ec[1] = 4'd2; ei[1] = 1'b1;
    op[2] = 4'b0100; fn[2] = 6'b111111; ec[2] = 4'd0; ei[2] = 1'b0;
    op[3] = 4'b0101; fn[3] = 6'b000000; ec[3] = 4'd1; ei[3] = 1'b0;
    op[4] = 4'b0010; fn[4] = 6'b100101; ec[4] = 4'd1; ei[4] = 1'b0;
    op[5] = 4'b0010; fn[5] = 6'b101010; ec[5] = 4'd7; ei[5] = 1'b0;
    op[6] = 4'b0110; fn[6] = 6'b000000; ec[6] = 4'd2; ei[6] = 1'b1;
    op[7] = 4'b0000; fn[7] = 6'b000000; ec[7] = 4'd2; ei[7] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, op[i], fn[i], 1'b1);
      tick();
      n_checks++;
      if (bus.ALUControl !== ec[i] || bus.Illegal !== ei[i] || bus.Busy !== 1'b0 ||
          bus.InReady !== 1'b1) begin
        n_fail++;
        $display("FAIL decode[%0d] got ctrl=%0d ill=%b busy=%b ir=%b want %0d %b 0 1", i,
                 bus.ALUControl, bus.Illegal, bus.Busy, bus.InReady, ec[i], ei[i]); end
    end
`ifndef ALU_DIV_EN
    drive(1'b1, 4'b0010, 6'b011010, 1'b1);
    tick();
    n_checks++; if (bus.ALUControl !== 4'd2 || bus.Illegal !== 1'b1) begin n_fail++;
      $display("FAIL div_disabled got ctrl=%0d ill=%b want 2 1", bus.ALUControl,
               bus.Illegal); end
`endif
    bus.InValid = 1'b0;
    tick();
    n_checks++; if (bus.OutValid !== 1'b0 || bus.Busy !== 1'b0) begin n_fail++;
      $display("FAIL decode_drain got ov=%b busy=%b want 0 0", bus.OutValid, bus.Busy); end
  endtask

  task automatic test_reset_busy();
    drive(1'b1, 4'b0011, 6'd0, 1'b1);
    tick();
    bus.InValid = 1'b0;
    tick();
    n_checks++; if (bus.Busy !== 1'b1) begin n_fail++;
      $display("FAIL rbusy_pre got busy=%b want 1", bus.Busy); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.OutValid !== 1'b0 || bus.Busy !== 1'b0 || bus.ALUControl !== 4'd0 ||
        bus.InReady !== 1'b0) begin
      n_fail++;
      $display("FAIL rbusy_abort got ov=%b busy=%b ctrl=%0d ir=%b want 0 0 0 0",
               bus.OutValid, bus.Busy, bus.ALUControl, bus.InReady); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_checks++; if (bus.InReady !== 1'b1 || bus.Busy !== 1'b0) begin n_fail++;
      $display("FAIL rbusy_release got ir=%b busy=%b want 1 0", bus.InReady, bus.Busy); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_multi(6'd0, 4'b0011, 4'd3, 3);
    test_multi(6'b000010, 4'b0010, 4'd3, 3);
`ifdef ALU_DIV_EN
    test_multi(6'b011010, 4'b0010, 4'd8, 7);
`endif
    test_hold();
    test_decode();
    test_reset_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
